// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Data-memory responder for the MEM stage of the pipelined RISC-V core.
// It holds a word-organised RAM and serves byte, halfword and word loads and
// stores with RV32I sign/zero extension. An accepted access stalls the
// pipeline for LATENCY cycles. It then spends one DONE cycle with stall low,
// and the pipeline advances at the end of that cycle.
//
// Parameters:
//   ADDR_WIDTH  word-address bits; the RAM holds 2^ADDR_WIDTH 32-bit words
//   LATENCY     stall cycles per accepted access (1..15)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   memRead     load request, held stable while stall=1
//   memWrite    store request, held stable while stall=1 (wins over memRead)
//   addr        byte address; bits above the word index are ignored
//   wdata       store data; the low bytes are used for SB/SH
//   funct3      000 B, 001 H, 010 W, 100 BU, 101 HU (other codes act as W)
//   rdata       registered, extended load result
//   stall       freezes PC and the IF/ID/EX/MEM registers
//   misaligned  the current request breaks alignment and is dropped

module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // First BUSY count: BUSY runs LATENCY-1 cycles, and it ends on cnt==0.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } sizeT;

  stateT state;
  stateT nextState;
  logic [3:0] cnt;
  logic [3:0] nextCnt;

  logic req;
  logic isStore;
  logic violation;
  logic commit;
  sizeT accessSize;
  logic signExtend;

  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [1:0] byteOff;
  logic [3:0] byteEn;
  logic [31:0] storeWord;
  logic [31:0] memWord;
  logic [7:0] laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadValue;

  logic [31:0] mem [0:DEPTH-1];

  // The address bits above the word index are ignored, so addresses wrap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[31:ADDR_WIDTH+2];

  assign req     = memRead | memWrite;
  assign isStore = memWrite;
  assign wordIdx = addr[ADDR_WIDTH+1:2];
  assign byteOff = addr[1:0];

  // Decode the access size, the extension mode and the alignment rule.
  always_comb begin
    accessSize = SIZE_WORD;
    signExtend = 1'b0;
    violation  = (addr[1:0] != 2'b00);
    case (funct3)
      3'b000: begin
        accessSize = SIZE_BYTE;
        signExtend = 1'b1;
        violation  = 1'b0;
      end
      3'b100: begin
        accessSize = SIZE_BYTE;
        violation  = 1'b0;
      end
      3'b001: begin
        accessSize = SIZE_HALF;
        signExtend = 1'b1;
        violation  = addr[0];
      end
      3'b101: begin
        accessSize = SIZE_HALF;
        violation  = addr[0];
      end
      default: begin
        accessSize = SIZE_WORD;
        signExtend = 1'b0;
        violation  = (addr[1:0] != 2'b00);
      end
    endcase
  end

  // Byte-lane enables and the store data replicated across the lanes.
  always_comb begin
    byteEn    = 4'b1111;
    storeWord = wdata;
    case (accessSize)
      SIZE_BYTE: begin
        byteEn    = 4'b0001 << byteOff;
        storeWord = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        byteEn    = addr[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{wdata[15:0]}};
      end
      default: begin
        byteEn    = 4'b1111;
        storeWord = wdata;
      end
    endcase
  end

  // Select the load lane and extend it.
  always_comb begin
    memWord  = mem[wordIdx];
    laneByte = memWord[8*byteOff +: 8];
    laneHalf = addr[1] ? memWord[31:16] : memWord[15:0];
    case (accessSize)
      SIZE_BYTE: loadValue = {{24{signExtend & laneByte[7]}}, laneByte};
      SIZE_HALF: loadValue = {{16{signExtend & laneHalf[15]}}, laneHalf};
      default:   loadValue = memWord;
    endcase
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next state and outputs. commit marks the edge that enters DONE, where
  // the store is written or the load result is captured. A request still
  // visible in DONE is not looked at, so it cannot be accepted twice.
  always_comb begin
    nextState  = state;
    nextCnt    = cnt;
    stall      = 1'b0;
    misaligned = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (violation) begin
            misaligned = 1'b1;
          end else begin
            stall = 1'b1;
            if (LATENCY == 1) begin
              nextState = DONE;
              commit    = 1'b1;
            end else begin
              nextState = BUSY;
              nextCnt   = CNT_INIT;
            end
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          nextState = DONE;
          commit    = 1'b1;
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    // While reset is held, stall and misaligned are forced low and nothing
    // may commit. This discards a store that is still in flight.
    if (!rst_n) begin
      stall      = 1'b0;
      misaligned = 1'b0;
      commit     = 1'b0;
    end
  end

  // RAM write port. Unselected lanes keep their contents. The RAM is not reset.
  always_ff @(posedge clk) begin
    if (commit && isStore) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[wordIdx][8*i +: 8] <= storeWord[8*i +: 8];
        end
      end
    end
  end

  // The load result holds until the next load commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
    end else if (commit && !isStore) begin
      rdata <= loadValue;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Bench for data_mem_responder. It runs three instances with LATENCY 2, 1
// and 15. Each issued access pushes its expected rdata and stall width into
// a queue. A monitor pops one entry on every DONE cycle of any instance and
// compares it.

module tb_data_mem_responder;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [2:0] memRead;
  logic [2:0] memWrite;
  logic [2:0][31:0] addr;
  logic [2:0][31:0] wdata;
  logic [2:0][2:0] funct3;
  logic [2:0][31:0] rdata;
  logic [2:0] stall;
  logic [2:0] misaligned;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .memRead(memRead[0]), .memWrite(memWrite[0]),
    .addr(addr[0]), .wdata(wdata[0]), .funct3(funct3[0]), .rdata(rdata[0]),
    .stall(stall[0]), .misaligned(misaligned[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .memRead(memRead[1]), .memWrite(memWrite[1]),
    .addr(addr[1]), .wdata(wdata[1]), .funct3(funct3[1]), .rdata(rdata[1]),
    .stall(stall[1]), .misaligned(misaligned[1])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) u2 (
    .clk(clk), .rst_n(rst_n), .memRead(memRead[2]), .memWrite(memWrite[2]),
    .addr(addr[2]), .wdata(wdata[2]), .funct3(funct3[2]), .rdata(rdata[2]),
    .stall(stall[2]), .misaligned(misaligned[2])
  );

  typedef struct {
    int inst;
    logic [31:0] rd;
    int lat;
    string name;
  } expT;

  expT expQ[$];
  int checks = 0;
  int passes = 0;
  logic [31:0] lastRd [3];
  int stallCnt [3];
  logic [2:0] prevStall;

  function automatic int latOf(input int k);
    case (k)
      0: return 2;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    memRead  = 3'b000;
    memWrite = 3'b000;
  endtask

  // Drive one aligned access on instance k, then wait until its DONE cycle
  // has passed. The task returns one cycle after DONE with the request still
  // driven, so a following call forms a back-to-back access.
  task automatic applyStimulus(input int k, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input logic [31:0] expRd,
                               input string name);
    expT e;
    int n;
    memRead[k]  = rd;
    memWrite[k] = wr;
    addr[k]     = a;
    wdata[k]    = d;
    funct3[k]   = f3;
    e.inst = k;
    e.lat  = latOf(k);
    e.name = name;
    if (wr) begin
      e.rd = lastRd[k];
    end else begin
      e.rd = expRd;
      lastRd[k] = expRd;
    end
    expQ.push_back(e);
    #1;
    checkOutput({name, " stall on accept"}, 32'(stall[k]), 32'd1);
    checkOutput({name, " misaligned"}, 32'(misaligned[k]), 32'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (stall[k] && n < 40);
    if (stall[k]) begin
      checkOutput({name, " stall timeout"}, 32'(stall[k]), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyMisaligned(input int k, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [2:0] f3,
                                 input string name);
    memRead[k]  = rd;
    memWrite[k] = wr;
    addr[k]     = a;
    wdata[k]    = 32'h5555_AAAA;
    funct3[k]   = f3;
    #1;
    checkOutput({name, " misaligned flag"}, 32'(misaligned[k]), 32'd1);
    checkOutput({name, " stall"}, 32'(stall[k]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " stays idle"}, 32'(stall[k]), 32'd0);
    checkOutput({name, " rdata kept"}, rdata[k], lastRd[k]);
    idleInputs();
  endtask

  task automatic store(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input string name);
    applyStimulus(k, 1'b0, 1'b1, a, d, f3, 32'd0, name);
  endtask

  task automatic load(input int k, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] expRd, input string name);
    applyStimulus(k, 1'b1, 1'b0, a, 32'd0, f3, expRd, name);
  endtask

  // Scoreboard monitor. It measures the stall width and checks rdata in the
  // DONE cycle, which is the first low-stall cycle after a high one.
  initial begin
    expT e;
    prevStall = 3'b000;
    for (int k = 0; k < 3; k++) stallCnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          stallCnt[k] = 0;
          prevStall[k] = 1'b0;
        end else begin
          if (stall[k]) begin
            stallCnt[k]++;
          end else if (prevStall[k]) begin
            if (expQ.size() == 0) begin
              checkOutput("unexpected DONE", 32'd1, 32'd0);
            end else begin
              e = expQ.pop_front();
              checkOutput({e.name, " instance"}, 32'(k), 32'(e.inst));
              checkOutput({e.name, " rdata"}, rdata[k], e.rd);
              checkOutput({e.name, " stall width"}, 32'(stallCnt[k]), 32'(e.lat));
            end
            stallCnt[k] = 0;
          end
          prevStall[k] = stall[k];
        end
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < 3; k++) lastRd[k] = 32'd0;
    addr   = '0;
    wdata  = '0;
    funct3 = '0;
    rst_n  = 1'b0;
    // A misaligned request during reset must not raise either output.
    memRead = 3'b111;
    memWrite = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h13;
      funct3[k] = F_W;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset stall u%0d", k), 32'(stall[k]), 32'd0);
      checkOutput($sformatf("reset misaligned u%0d", k), 32'(misaligned[k]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    idleInputs();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("post-reset rdata u%0d", k), rdata[k], 32'd0);
      checkOutput($sformatf("post-reset stall u%0d", k), 32'(stall[k]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Basic word, byte and halfword traffic on the LATENCY=2 instance.
    store(0, 32'h10, 32'hDEAD_BEEF, F_W, "SW 0x10");
    load(0, 32'h10, F_W, 32'hDEAD_BEEF, "LW 0x10");
    store(0, 32'h11, 32'hAAAA_AA7F, F_B, "SB 0x11");
    load(0, 32'h11, F_B, 32'h0000_007F, "LB 0x11");
    load(0, 32'h11, F_BU, 32'h0000_007F, "LBU 0x11");
    load(0, 32'h10, F_W, 32'hDEAD_7FEF, "LW after SB");
    store(0, 32'h12, 32'h5555_8001, F_H, "SH 0x12");
    load(0, 32'h12, F_H, 32'hFFFF_8001, "LH 0x12");
    load(0, 32'h12, F_HU, 32'h0000_8001, "LHU 0x12");
    load(0, 32'h13, F_B, 32'hFFFF_FF80, "LB 0x13");
    load(0, 32'h13, F_BU, 32'h0000_0080, "LBU 0x13");
    store(0, 32'h20, 32'hCAFE_F00D, F_W, "SW 0x20");
    idleInputs();
    @(posedge clk);
    #1;

    // Misaligned requests are dropped without a stall or any state change.
    applyMisaligned(0, 1'b1, 1'b0, 32'h13, F_W, "LW 0x13");
    applyMisaligned(0, 1'b0, 1'b1, 32'h21, F_H, "SH 0x21");
    applyMisaligned(0, 1'b1, 1'b0, 32'h22, 3'b011, "funct3 011 0x22");
    load(0, 32'h20, F_W, 32'hCAFE_F00D, "LW 0x20 unchanged");
    load(0, 32'h20, 3'b110, 32'hCAFE_F00D, "funct3 110 as LW");
    // When both read and write are set, the access is a store.
    applyStimulus(0, 1'b1, 1'b1, 32'h24, 32'h1111_2222, F_W, 32'd0, "RW both 0x24");
    load(0, 32'h24, F_W, 32'h1111_2222, "LW 0x24");

    // Reset during BUSY discards the store in flight.
    store(0, 32'h30, 32'h0, F_W, "SW 0 0x30");
    memRead[0] = 1'b0;
    memWrite[0] = 1'b1;
    addr[0] = 32'h30;
    wdata[0] = 32'h1234_5678;
    funct3[0] = F_W;
    #1;
    checkOutput("abort accept stall", 32'(stall[0]), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("abort busy stall", 32'(stall[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort stall drop", 32'(stall[0]), 32'd0);
    checkOutput("abort rdata cleared", rdata[0], 32'd0);
    for (int k = 0; k < 3; k++) lastRd[k] = 32'd0;
    idleInputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // This load follows a reset, so the first value is 0x80 from LBU 0x13.
    load(0, 32'h13, F_BU, 32'h0000_0080, "LBU 0x13 after reset");
    load(0, 32'h30, F_W, 32'h0000_0000, "LW 0x30 store discarded");
    idleInputs();
    @(posedge clk);
    #1;

    // LATENCY=1: back-to-back traffic and address aliasing.
    store(1, 32'h1000, 32'hA5A5_0001, F_W, "L1 SW 0x1000");
    load(1, 32'h0, F_W, 32'hA5A5_0001, "L1 LW 0x0 alias");
    load(1, 32'h1000, F_W, 32'hA5A5_0001, "L1 LW 0x1000");
    store(1, 32'h1003, 32'h0000_005A, F_B, "L1 SB 0x1003");
    load(1, 32'h3, F_BU, 32'h0000_005A, "L1 LBU 0x3");
    load(1, 32'h0, F_W, 32'h5AA5_0001, "L1 LW after SB");
    idleInputs();
    @(posedge clk);
    #1;

    // LATENCY=15: the maximum counter run.
    store(2, 32'h4, 32'h0BAD_F00D, F_W, "L15 SW 0x4");
    load(2, 32'h1004, F_W, 32'h0BAD_F00D, "L15 LW 0x1004");
    load(2, 32'h1006, F_H, 32'h0000_0BAD, "L15 LH 0x1006");
    load(2, 32'h5, F_B, 32'hFFFF_FFF0, "L15 LB 0x5");
    idleInputs();

    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder at the MEM stage of the pipelined RISC-V core. It answers the memRead/memWrite requests raised by the main decoder and carried down the pipeline, and it holds an internal word-organised RAM. The block performs byte, halfword and word loads and stores with RV32I sign/zero extension. While an access is in flight it stalls the pipeline for a parameterised number of cycles.

## Interface
- ADDR_WIDTH, 10: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: stall cycles per accepted access; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- memRead  input  1  load request, held stable by the pipeline while stall=1.
- memWrite  input  1  store request, held stable by the pipeline while stall=1.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rs2); the low bytes are used for SB/SH.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  extended load result, registered.
- stall  output  1  freezes the PC and the IF/ID/EX/MEM registers when 1.
- misaligned  output  1  the current request violates alignment; the access is dropped.

## Operation
- States: IDLE, BUSY, DONE; reset state is IDLE. Latency counter is 4 bits.
- req = memRead | memWrite. If both are set, the request is a store; the read is ignored.
- Word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Alignment rules:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - B/BU is always aligned.
  - Any other funct3 value behaves as W.
- misaligned = req & violation & (state==IDLE), combinational. A misaligned request causes no stall, no RAM write and no rdata change; it stays in IDLE.
- IDLE with an aligned req: stall=1. If LATENCY==1, next state is DONE. Otherwise next state is BUSY with cnt=LATENCY-2.
- BUSY: stall=1. If cnt==0, next state is DONE; otherwise cnt decrements.
- Commit happens on the edge that enters DONE:
  - Store: byte lanes are written per size and addr[1:0]; unselected lanes are unchanged.
  - Load: the selected lane is extended into rdata (B/H sign-extend, BU/HU zero-extend).
- DONE: stall=0 and the pipeline advances at the end of this cycle. Next state is IDLE unconditionally; the request still visible in DONE is never re-accepted.
- rdata holds its value until the next load commits. Stores and misaligned requests do not change it.
- RAM contents are not reset.

## Timing
- Reset values (while rst_n=0 and immediately after): state=IDLE, cnt=0, rdata=0, stall=0, misaligned=0. Both stall and misaligned are forced 0 during reset.
- Reset mid-access: the block returns to IDLE immediately, an uncommitted store is discarded, and rdata=0.
- An aligned request first seen in cycle n gives stall=1 in cycles n..n+LATENCY-1. DONE is cycle n+LATENCY, with the new rdata valid in that cycle.
- Back-to-back accesses: the next request is first visible in the cycle after DONE and is accepted from IDLE. Minimum spacing is LATENCY+1 cycles.
- stall and misaligned are combinational from memRead/memWrite/addr/funct3 in IDLE; no registered delay.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 with LATENCY=2 -> stall high for exactly 2 cycles per access; rdata=0xDEADBEEF in DONE.
- SB 0x7F @0x11, then LB and LBU @0x11, and LW @0x10 -> LB/LBU give 0x0000007F; LW gives 0xDEAD7FEF.
- SH 0x8001 @0x12, then LH and LHU @0x12 -> LH gives 0xFFFF8001; LHU gives 0x00008001.
- LW @0x13 and SH @0x21 -> misaligned=1 the same cycle, stall=0, a later LW @0x20 shows the word unchanged, and rdata keeps its previous value.
- Assert rst_n=0 during BUSY of SW 0x12345678 @0x30 -> stall drops immediately and rdata=0; a later LW @0x30 does not return 0x12345678 (pre-seed with SW 0 first).
- Sweep LATENCY=1 and 15 with back-to-back LW/SW -> stall width equals LATENCY, DONE lasts one cycle with no re-accept, and an addr of 0x1000 aliases to 0x0 for ADDR_WIDTH=10.
